execute_load_store_sequencer: RTL and testbench

Sequences load/store requests from the execute-stage load/store datapath onto the single data-memory port. It holds one outstanding access, stalls execute through a busy handshake, and waits for load data. It extracts the addressed byte, halfword or word and returns a writeback result with a fault flag. It also handles pipeline flush, misaligned-access faults and response timeout.

---
 rtl/execute_load_store_sequencer_pkg.sv | 27 ++
 rtl/execute_load_store_extract.sv | 23 ++
 rtl/execute_load_store_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_execute_load_store_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_load_store_sequencer_pkg.sv
// Shared encodings for the execute-stage load/store sequencer:
// access order, FSM state, default tag width and the latched request bundle.
package execute_load_store_sequencer_pkg;

    localparam int TAG_W_DEF = 5;

    localparam logic [1:0] ORDER_BYTE = 2'd0;
    localparam logic [1:0] ORDER_HALF = 2'd1;
    localparam logic [1:0] ORDER_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic        rw;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  order;
        logic [1:0]  shift;
        logic [3:0]  mask;
    } req_t;

endpackage

// File: rtl/execute_load_store_extract.sv
// Load-data lane extraction: shifts the response right by whole bytes and
// zero-extends byte/half/word. Ports: iDATA, iSHIFT, iORDER in; oDATA out.
module execute_load_store_extract
    import execute_load_store_sequencer_pkg::*;
(
    input  logic [31:0] iDATA,
    input  logic [1:0]  iSHIFT,
    input  logic [1:0]  iORDER,
    output logic [31:0] oDATA
);

    logic [31:0] shifted;

    always_comb begin
        shifted = iDATA >> {iSHIFT, 3'b000};
        unique case (iORDER)
            ORDER_BYTE: oDATA = {24'h0, shifted[7:0]};
            ORDER_HALF: oDATA = {16'h0, shifted[15:0]};
            default:    oDATA = shifted;
        endcase
    end

endmodule

// File: rtl/execute_load_store_sequencer.sv
// Single-outstanding load/store sequencer between execute and the data-memory
// port. Ports: iCLOCK/inRESET/iFLUSH; iREQ_* request with oREQ_BUSY stall;
// oDATAIO_* request with iDATAIO_BUSY, iDATAIO_VALID/DATA load response;
// oWB_* one-cycle writeback pulse with extracted data and fault flag.
module execute_load_store_sequencer
    import execute_load_store_sequencer_pkg::*;
#(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic             iFLUSH,
    input  logic             iREQ_VALID,
    output logic             oREQ_BUSY,
    input  logic             iREQ_RW,
    input  logic [31:0]      iREQ_PDT,
    input  logic [31:0]      iREQ_ADDR,
    input  logic [31:0]      iREQ_DATA,
    input  logic [1:0]       iREQ_ORDER,
    input  logic [1:0]       iREQ_LOAD_SHIFT,
    input  logic [3:0]       iREQ_LOAD_MASK,
    input  logic [TAG_W-1:0] iREQ_TAG,
    output logic             oDATAIO_REQ,
    input  logic             iDATAIO_BUSY,
    output logic             oDATAIO_RW,
    output logic [31:0]      oDATAIO_PDT,
    output logic [31:0]      oDATAIO_ADDR,
    output logic [31:0]      oDATAIO_DATA,
    output logic [1:0]       oDATAIO_ORDER,
    output logic [3:0]       oDATAIO_MASK,
    input  logic             iDATAIO_VALID,
    input  logic [31:0]      iDATAIO_DATA,
    output logic             oWB_VALID,
    output logic             oWB_RW,
    output logic [TAG_W-1:0] oWB_TAG,
    output logic [31:0]      oWB_DATA,
    output logic             oWB_FAULT
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stale_q, stale_d;
    logic               busy_q, busy_d;
    logic               dreq_q, dreq_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_rw_q, wb_rw_d;
    logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_fault_q, wb_fault_d;

    logic               accept;
    logic               rsp_ok;
    logic               timeout_hit;
    logic [31:0]        ext_data;

    execute_load_store_extract u_extract (
        .iDATA  (iDATAIO_DATA),
        .iSHIFT (req_q.shift),
        .iORDER (req_q.order),
        .oDATA  (ext_data)
    );

    always_comb begin
        accept      = iREQ_VALID && !busy_q && !iFLUSH;
        rsp_ok      = iDATAIO_VALID && !stale_q;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

        state_d    = state_q;
        req_d      = req_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        stale_d    = stale_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = req_q.rw;
        wb_tag_d   = tag_q;
        wb_data_d  = '0;
        wb_fault_d = 1'b0;

        // A response owed to an abandoned load is swallowed wherever it lands.
        if (iDATAIO_VALID && stale_q) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.rw    = iREQ_RW;
                    req_d.pdt   = iREQ_PDT;
                    req_d.addr  = iREQ_ADDR;
                    req_d.data  = iREQ_DATA;
                    req_d.order = iREQ_ORDER;
                    req_d.shift = iREQ_LOAD_SHIFT;
                    req_d.mask  = iREQ_LOAD_MASK;
                    tag_d       = iREQ_TAG;
                    if (iREQ_LOAD_MASK == 4'b0000) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = iREQ_RW;
                        wb_tag_d   = iREQ_TAG;
                        wb_fault_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!iDATAIO_BUSY) begin
                    // Memory took the access; a flush cannot recall it.
                    if (req_q.rw) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                    end else if (iFLUSH) begin
                        state_d = ST_IDLE;
                        stale_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end else if (iFLUSH) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rsp_ok) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ext_data;
                end else if (timeout_hit) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_fault_d = 1'b1;
                    stale_d    = 1'b1;
                end
                if (iFLUSH) begin
                    state_d = ST_IDLE;
                    // Only still-owed responses need discarding.
                    if (!rsp_ok) begin
                        stale_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (iFLUSH) begin
            wb_valid_d = 1'b0;
        end
        if (!wb_valid_d) begin
            wb_rw_d    = 1'b0;
            wb_tag_d   = '0;
            wb_data_d  = '0;
            wb_fault_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        dreq_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            stale_q    <= 1'b0;
            busy_q     <= 1'b0;
            dreq_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            wb_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            busy_q     <= busy_d;
            dreq_q     <= dreq_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign oREQ_BUSY     = busy_q;
    assign oDATAIO_REQ   = dreq_q;
    assign oDATAIO_RW    = req_q.rw;
    assign oDATAIO_PDT   = req_q.pdt;
    assign oDATAIO_ADDR  = req_q.addr;
    assign oDATAIO_DATA  = req_q.data;
    assign oDATAIO_ORDER = req_q.order;
    assign oDATAIO_MASK  = req_q.mask;
    assign oWB_VALID     = wb_valid_q;
    assign oWB_RW        = wb_rw_q;
    assign oWB_TAG       = wb_tag_q;
    assign oWB_DATA      = wb_data_q;
    assign oWB_FAULT     = wb_fault_q;

endmodule

// File: tb/tb_execute_load_store_sequencer.sv
// Bench for execute_load_store_sequencer: scripted scenarios with a
// writeback scoreboard drained by a negedge monitor.
module tb_execute_load_store_sequencer;
    import execute_load_store_sequencer_pkg::*;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req_valid;
    logic          req_busy;
    logic          req_rw;
    logic [31:0]   req_pdt;
    logic [31:0]   req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_order;
    logic [1:0]    req_shift;
    logic [3:0]    req_mask;
    logic [TW-1:0] req_tag;
    logic          dreq;
    logic          dbusy;
    logic          drw;
    logic [31:0]   dpdt;
    logic [31:0]   daddr;
    logic [31:0]   ddata;
    logic [1:0]    dorder;
    logic [3:0]    dmask;
    logic          dvalid;
    logic [31:0]   drdata;
    logic          wb_valid;
    logic          wb_rw;
    logic [TW-1:0] wb_tag;
    logic [31:0]   wb_data;
    logic          wb_fault;

    always #5 clk = ~clk;

    execute_load_store_sequencer #(.TAG_W(TW), .TIMEOUT(8)) dut (
        .iCLOCK          (clk),
        .inRESET         (rst_n),
        .iFLUSH          (flush),
        .iREQ_VALID      (req_valid),
        .oREQ_BUSY       (req_busy),
        .iREQ_RW         (req_rw),
        .iREQ_PDT        (req_pdt),
        .iREQ_ADDR       (req_addr),
        .iREQ_DATA       (req_data),
        .iREQ_ORDER      (req_order),
        .iREQ_LOAD_SHIFT (req_shift),
        .iREQ_LOAD_MASK  (req_mask),
        .iREQ_TAG        (req_tag),
        .oDATAIO_REQ     (dreq),
        .iDATAIO_BUSY    (dbusy),
        .oDATAIO_RW      (drw),
        .oDATAIO_PDT     (dpdt),
        .oDATAIO_ADDR    (daddr),
        .oDATAIO_DATA    (ddata),
        .oDATAIO_ORDER   (dorder),
        .oDATAIO_MASK    (dmask),
        .iDATAIO_VALID   (dvalid),
        .iDATAIO_DATA    (drdata),
        .oWB_VALID       (wb_valid),
        .oWB_RW          (wb_rw),
        .oWB_TAG         (wb_tag),
        .oWB_DATA        (wb_data),
        .oWB_FAULT       (wb_fault)
    );

    typedef struct {
        logic          rw;
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          fault;
        int            cyc;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_acc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dreq && !dbusy) n_acc <= n_acc + 1;
    end

    always @(negedge clk) begin
        sb_t e;
        if (wb_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got tag=%0d data=%h fault=%b, required no writeback",
                         wb_tag, wb_data, wb_fault);
            end else begin
                e = sbq.pop_front();
                if ({wb_rw, wb_tag, wb_data, wb_fault} !== {e.rw, e.tag, e.data, e.fault}) begin
                    errors++;
                    $display("FAIL wb_result: got rw=%b tag=%0d data=%h fault=%b, required rw=%b tag=%0d data=%h fault=%b",
                             wb_rw, wb_tag, wb_data, wb_fault, e.rw, e.tag, e.data, e.fault);
                end
                if (e.cyc >= 0) begin
                    checks++;
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL wb_latency: got cycle %0d, required %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic rw, input logic [TW-1:0] tag,
                             input logic [31:0] data, input logic fault, input int c);
        sb_t e;
        e.rw = rw; e.tag = tag; e.data = data; e.fault = fault; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] order, input logic [1:0] shift,
                             input logic [3:0] mask, input logic [TW-1:0] tag);
        req_valid = 1'b1; req_rw = rw; req_pdt = 32'h0000_A000 | addr;
        req_addr = addr; req_data = data; req_order = order;
        req_shift = shift; req_mask = mask; req_tag = tag;
        step();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        dvalid = 1'b1; drdata = d;
        step();
        dvalid = 1'b0; drdata = 32'h0;
    endtask

    task automatic run_load(input logic [1:0] order, input logic [1:0] shift, input logic [3:0] mask,
                            input logic [TW-1:0] tag, input logic [31:0] rsp, input logic [31:0] exp_d);
        expect_wb(1'b0, tag, exp_d, 1'b0, -1);
        drive_req(1'b0, 32'h0000_0040, 32'h0, order, shift, mask, tag);
        step();
        respond(rsp);
        step();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (req_busy && n < 40) begin
            step();
            n++;
        end
        if (req_busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", req_busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; req_valid = 0; req_rw = 0; req_pdt = 0;
        req_addr = 0; req_data = 0; req_order = 0; req_shift = 0; req_mask = 0;
        req_tag = 0; dbusy = 0; dvalid = 0; drdata = 0;
        #1;
        checks++;
        if ({req_busy, dreq, wb_valid, wb_fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/req/wb/fault=%b, required 0000",
                     {req_busy, dreq, wb_valid, wb_fault});
        end
        checks++;
        if ({daddr, ddata, wb_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h wb=%h, required 0", daddr, ddata, wb_data);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load32();
        int a0 = cyc;
        expect_wb(1'b0, 5'd1, 32'hDEAD_BEEF, 1'b0, a0 + 3);
        drive_req(1'b0, 32'h100, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd1);
        checks++;
        if ({dreq, req_busy, drw} !== 3'b110 || daddr !== 32'h100 || dmask !== 4'hF
            || dorder !== ORDER_WORD || dpdt !== 32'h0000_A100) begin
            errors++;
            $display("FAIL load32_issue: got req=%b busy=%b addr=%h mask=%h pdt=%h, required 1 1 100 f 0000a100",
                     dreq, req_busy, daddr, dmask, dpdt);
        end
        step();
        checks++;
        if (dreq !== 1'b0) begin
            errors++;
            $display("FAIL load32_req_drop: got req=%b, required 0", dreq);
        end
        respond(32'hDEAD_BEEF);
        checks++;
        if (req_busy !== 1'b0) begin
            errors++;
            $display("FAIL load32_busy_drop: got busy=%b, required 0", req_busy);
        end
        step();
    endtask

    task automatic test_lanes();
        run_load(ORDER_BYTE, 2'd2, 4'b0100, 5'd2, 32'h1122_3344, 32'h0000_0022);
        run_load(ORDER_HALF, 2'd2, 4'b1100, 5'd3, 32'h1122_3344, 32'h0000_1122);
        run_load(ORDER_BYTE, 2'd0, 4'b0001, 5'd4, 32'hFFEE_DDCC, 32'h0000_00CC);
    endtask

    task automatic test_store_busy();
        int a0 = cyc;
        int acc0 = n_acc;
        dbusy = 1'b1;
        expect_wb(1'b1, 5'd6, 32'h0, 1'b0, a0 + 5);
        drive_req(1'b1, 32'h200, 32'hCAFE_F00D, ORDER_WORD, 2'd0, 4'hF, 5'd6);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dreq !== 1'b1 || drw !== 1'b1 || daddr !== 32'h200 || ddata !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL store_hold[%0d]: got req=%b rw=%b addr=%h data=%h, required 1 1 200 cafef00d",
                         i, dreq, drw, daddr, ddata);
            end
            if (i == 3) dbusy = 1'b0;
            step();
        end
        checks++;
        if (dreq !== 1'b0 || n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL store_accept: got req=%b accepts=%0d, required 0 and 1", dreq, n_acc - acc0);
        end
        step();
    endtask

    task automatic test_misaligned();
        int a0 = cyc;
        expect_wb(1'b0, 5'd7, 32'h0, 1'b1, a0 + 1);
        drive_req(1'b0, 32'h301, 32'h0, ORDER_HALF, 2'd1, 4'b0000, 5'd7);
        checks++;
        if (dreq !== 1'b0 || req_busy !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noreq: got req=%b busy=%b, required 0 0", dreq, req_busy);
        end
        expect_wb(1'b0, 5'd8, 32'hA5A5_0F0F, 1'b0, -1);
        drive_req(1'b0, 32'h304, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd8);
        checks++;
        if (dreq !== 1'b1 || req_busy !== 1'b1 || daddr !== 32'h304) begin
            errors++;
            $display("FAIL misalign_next: got req=%b busy=%b addr=%h, required 1 1 304", dreq, req_busy, daddr);
        end
        step();
        respond(32'hA5A5_0F0F);
        step();
    endtask

    task automatic test_timeout();
        int n;
        expect_wb(1'b0, 5'd9, 32'h0, 1'b1, -1);
        drive_req(1'b0, 32'h400, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd9);
        wait_idle(n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles to idle, required 9", n);
        end
        step();
        respond(32'h0000_0055);
        step();
        run_load(ORDER_WORD, 2'd0, 4'hF, 5'd10, 32'h0000_0066, 32'h0000_0066);
        expect_wb(1'b0, 5'd11, 32'h0, 1'b1, -1);
        drive_req(1'b0, 32'h404, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd11);
        wait_idle(n);
        expect_wb(1'b0, 5'd12, 32'h0000_0066, 1'b0, -1);
        drive_req(1'b0, 32'h408, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd12);
        step();
        respond(32'h0000_0055);
        checks++;
        if (req_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_in_wait: got busy=%b after stale pulse, required 1", req_busy);
        end
        respond(32'h0000_0066);
        step();
    endtask

    task automatic test_flush();
        int acc0;
        req_valid = 1'b1; req_mask = 4'hF; req_tag = 5'd13; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        checks++;
        if (req_busy !== 1'b0 || dreq !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b req=%b, required 0 0", req_busy, dreq);
        end
        step();
        drive_req(1'b0, 32'h500, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd14);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (req_busy !== 1'b0 || dreq !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait: got busy=%b req=%b, required 0 0", req_busy, dreq);
        end
        respond(32'h0000_0077);
        step();
        run_load(ORDER_WORD, 2'd0, 4'hF, 5'd15, 32'h0000_0088, 32'h0000_0088);
        dbusy = 1'b1;
        acc0 = n_acc;
        drive_req(1'b1, 32'h504, 32'h1234_5678, ORDER_WORD, 2'd0, 4'hF, 5'd16);
        flush = 1'b1;
        step();
        flush = 1'b0; dbusy = 1'b0;
        checks++;
        if (req_busy !== 1'b0 || dreq !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue: got busy=%b req=%b, required 0 0", req_busy, dreq);
        end
        step(); step();
        checks++;
        if (n_acc !== acc0) begin
            errors++;
            $display("FAIL flush_issue_acc: got %0d accepts, required %0d", n_acc, acc0);
        end
    endtask

    task automatic test_reset_mid_issue();
        dbusy = 1'b1;
        drive_req(1'b0, 32'h600, 32'h0, ORDER_WORD, 2'd0, 4'hF, 5'd17);
        checks++;
        if (dreq !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got req=%b, required 1", dreq);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dreq, req_busy, drw, wb_valid, wb_fault} !== 5'b0 || daddr !== 32'h0
            || dpdt !== 32'h0 || dmask !== 4'h0 || dorder !== 2'd0) begin
            errors++;
            $display("FAIL rst_async: got req=%b busy=%b addr=%h pdt=%h mask=%h, required all 0",
                     dreq, req_busy, daddr, dpdt, dmask);
        end
        step();
        rst_n = 1'b1; dbusy = 1'b0;
        step();
        run_load(ORDER_HALF, 2'd0, 4'b0011, 5'd18, 32'hBEEF_CAFE, 32'h0000_CAFE);
    endtask

    initial begin
        test_reset();
        test_load32();
        test_lanes();
        test_store_busy();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid_issue();
        step(); step();
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending writebacks, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
